// File: rtl/mem_wait_ctrl.sv
// Arbitrates instruction fetches and data accesses from a core onto one shared,
// ack-terminated memory port, stalling each requester with a wait signal until its access completes.
module mem_wait_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_en,
    input  logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_rdata,
    output logic          imem_wait,
    input  logic          dmem_en,
    input  logic          dmem_we,
    input  logic [AW-1:0] dmem_addr,
    input  logic [DW-1:0] dmem_wdata,
    output logic [DW-1:0] dmem_rdata,
    output logic          dmem_wait,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err,
    output logic [2:0]    dbg_state
);

    // Handshake: a requester raises *_en and holds it while *_wait=1; the access is
    // complete in the first cycle *_wait drops with *_en high. On the memory side
    // mem_req stays high with stable attributes until the single-cycle mem_ack.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DACC  = 3'd1,
        IACC  = 3'd2,
        DDONE = 3'd3,
        IDONE = 3'd4
    } state_t;

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          expire;

    assign busy   = (state == DACC) || (state == IACC);
    // An ack in the final allowed cycle wins over the timeout.
    assign expire = busy && !mem_ack && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dmem_en) begin
                    state_next = DACC;
                end else if (imem_en) begin
                    state_next = IACC;
                end
            end
            DACC:    if (mem_ack || expire) state_next = DDONE;
            IACC:    if (mem_ack || expire) state_next = IDONE;
            DDONE:   state_next = IDLE;
            IDONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = busy;
        dmem_wait = dmem_en && (state != DDONE);
        imem_wait = imem_en && (state != IDONE);
        dbg_state = state;
    end

    // Cycle counter runs only while an access is outstanding; it is zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (busy && state_next == state) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE) begin
            if (dmem_en) begin
                mem_we    <= dmem_we;
                mem_addr  <= dmem_addr;
                mem_wdata <= dmem_wdata;
            end else if (imem_en) begin
                mem_we    <= 1'b0;
                mem_addr  <= imem_addr;
                mem_wdata <= '0;
            end
        end
    end

    // A timed-out access returns zero data and raises the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_rdata <= '0;
            imem_rdata <= '0;
            err        <= 1'b0;
        end else begin
            if (state == DACC && (mem_ack || expire)) begin
                dmem_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (state == IACC && (mem_ack || expire)) begin
                imem_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule
